id_ex_stage_buffer: RTL and testbench

ID/EX pipeline buffer for the 5-stage RISCV core. It registers the decoded instruction fields and operands from decode and presents them to execute and to the forward controller. It detects load-use hazards against the instruction currently in EX, inserts one bubble and raises a stall to the IF/ID stage. It also squashes on a taken-branch flush and counts stall and flush bubbles.

---
 rtl/id_ex_stage_buffer.sv | 115 +++++++++++
 tb/tb_id_ex_stage_buffer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_buffer.sv
// ID/EX pipeline register with load-use bubble insertion, flush squash and saturating bubble counters.
// Optional build macro: LOAD_USE_STALL_EN enables load-use hazard detection and stall counting.
package id_ex_stage_buffer_pkg;
  typedef enum logic [1:0] {
    NO_WRITEBACK = 2'd0,
    WB_ALU       = 2'd1,
    WB_LOAD      = 2'd2,
    WB_PC4       = 2'd3
  } write_back_mux_selector;

  localparam logic [6:0] OPCODE_OP    = 7'h33;
  localparam logic [6:0] OPCODE_OPIMM = 7'h13;
  localparam logic [6:0] OPCODE_LOAD  = 7'h03;
endpackage

module id_ex_stage_buffer
  import id_ex_stage_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid_ip,
  input  logic [6:0]             id_instr_opcode_ip,
  input  logic [4:0]             id_rs1_ip,
  input  logic [4:0]             id_rs2_ip,
  input  logic [4:0]             id_dest_ip,
  input  write_back_mux_selector id_wb_mux_ip,
  input  logic [DATA_WIDTH-1:0]  id_rs1_data_ip,
  input  logic [DATA_WIDTH-1:0]  id_rs2_data_ip,
  input  logic [DATA_WIDTH-1:0]  id_imm_ip,
  input  logic [DATA_WIDTH-1:0]  id_pc_ip,
  input  logic                   ex_flush_ip,
  output logic                   ex_valid_op,
  output logic [6:0]             ex_instr_opcode_op,
  output logic [4:0]             ex_rs1_op,
  output logic [4:0]             ex_rs2_op,
  output logic [4:0]             ex_dest_op,
  output write_back_mux_selector ex_wb_mux_op,
  output logic [DATA_WIDTH-1:0]  ex_rs1_data_op,
  output logic [DATA_WIDTH-1:0]  ex_rs2_data_op,
  output logic [DATA_WIDTH-1:0]  ex_imm_op,
  output logic [DATA_WIDTH-1:0]  ex_pc_op,
  output logic                   stall_op,
  output logic [CNT_WIDTH-1:0]   stall_cnt_op,
  output logic [CNT_WIDTH-1:0]   flush_cnt_op
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic hazard;
  logic load_bubble;

`ifdef LOAD_USE_STALL_EN
  logic rs1_used;
  logic rs2_used;

  always_comb begin
    rs1_used = (id_instr_opcode_ip == OPCODE_OP) ||
               (id_instr_opcode_ip == OPCODE_OPIMM) ||
               (id_instr_opcode_ip == OPCODE_LOAD);
    rs2_used = (id_instr_opcode_ip == OPCODE_OP);
    // Only the EX register contents and decode inputs feed this term.
    hazard = ex_valid_op && (ex_instr_opcode_op == OPCODE_LOAD) &&
             (ex_dest_op != 5'd0) && id_valid_ip &&
             ((rs1_used && (id_rs1_ip == ex_dest_op)) ||
              (rs2_used && (id_rs2_ip == ex_dest_op)));
  end
`else
  assign hazard = 1'b0;
`endif

  assign stall_op    = hazard && !ex_flush_ip && reset;
  assign load_bubble = !reset || ex_flush_ip || stall_op || !id_valid_ip;

  always_ff @(posedge clk) begin
    if (load_bubble) begin
      ex_valid_op        <= 1'b0;
      ex_instr_opcode_op <= 7'h00;
      ex_rs1_op          <= 5'd0;
      ex_rs2_op          <= 5'd0;
      ex_dest_op         <= 5'd0;
      ex_wb_mux_op       <= NO_WRITEBACK;
      ex_rs1_data_op     <= '0;
      ex_rs2_data_op     <= '0;
      ex_imm_op          <= '0;
      ex_pc_op           <= '0;
    end else begin
      ex_valid_op        <= 1'b1;
      ex_instr_opcode_op <= id_instr_opcode_ip;
      ex_rs1_op          <= id_rs1_ip;
      ex_rs2_op          <= id_rs2_ip;
      ex_dest_op         <= id_dest_ip;
      ex_wb_mux_op       <= id_wb_mux_ip;
      ex_rs1_data_op     <= id_rs1_data_ip;
      ex_rs2_data_op     <= id_rs2_data_ip;
      ex_imm_op          <= id_imm_ip;
      ex_pc_op           <= id_pc_ip;
    end
  end

  // Flush outranks stall, so at most one counter moves per cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_op <= '0;
      flush_cnt_op <= '0;
    end else if (ex_flush_ip) begin
      if (flush_cnt_op != '1) flush_cnt_op <= flush_cnt_op + CNT_ONE;
    end else if (stall_op) begin
      if (stall_cnt_op != '1) stall_cnt_op <= stall_cnt_op + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_buffer.sv
// Self-checking bench for id_ex_stage_buffer; a narrow-counter second instance exercises saturation.
module tb_id_ex_stage_buffer;
  import id_ex_stage_buffer_pkg::*;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int SW = 4;
  localparam int VW = 1 + 7 + 15 + 2 + 4 * DW;
`ifdef LOAD_USE_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, id_valid, flush;
  logic [6:0] id_op;
  logic [4:0] id_rs1, id_rs2, id_dest;
  write_back_mux_selector id_wb;
  logic [DW-1:0] id_d1, id_d2, id_imm, id_pc;

  logic ex_valid, stall;
  logic [6:0] ex_op;
  logic [4:0] ex_rs1, ex_rs2, ex_dest;
  write_back_mux_selector ex_wb;
  logic [DW-1:0] ex_d1, ex_d2, ex_imm, ex_pc;
  logic [CW-1:0] stall_cnt, flush_cnt;

  logic s_valid, s_stall;
  logic [6:0] s_op;
  logic [4:0] s_rs1, s_rs2, s_dest;
  write_back_mux_selector s_wb;
  logic [DW-1:0] s_d1, s_d2, s_imm, s_pc;
  logic [SW-1:0] s_stall_cnt, s_flush_cnt;

  always #5 clk = ~clk;

  id_ex_stage_buffer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .id_valid_ip(id_valid), .id_instr_opcode_ip(id_op),
    .id_rs1_ip(id_rs1), .id_rs2_ip(id_rs2), .id_dest_ip(id_dest), .id_wb_mux_ip(id_wb),
    .id_rs1_data_ip(id_d1), .id_rs2_data_ip(id_d2), .id_imm_ip(id_imm), .id_pc_ip(id_pc),
    .ex_flush_ip(flush), .ex_valid_op(ex_valid), .ex_instr_opcode_op(ex_op),
    .ex_rs1_op(ex_rs1), .ex_rs2_op(ex_rs2), .ex_dest_op(ex_dest), .ex_wb_mux_op(ex_wb),
    .ex_rs1_data_op(ex_d1), .ex_rs2_data_op(ex_d2), .ex_imm_op(ex_imm), .ex_pc_op(ex_pc),
    .stall_op(stall), .stall_cnt_op(stall_cnt), .flush_cnt_op(flush_cnt)
  );

  id_ex_stage_buffer #(.DATA_WIDTH(DW), .CNT_WIDTH(SW)) small_dut (
    .clk(clk), .reset(reset), .id_valid_ip(id_valid), .id_instr_opcode_ip(id_op),
    .id_rs1_ip(id_rs1), .id_rs2_ip(id_rs2), .id_dest_ip(id_dest), .id_wb_mux_ip(id_wb),
    .id_rs1_data_ip(id_d1), .id_rs2_data_ip(id_d2), .id_imm_ip(id_imm), .id_pc_ip(id_pc),
    .ex_flush_ip(flush), .ex_valid_op(s_valid), .ex_instr_opcode_op(s_op),
    .ex_rs1_op(s_rs1), .ex_rs2_op(s_rs2), .ex_dest_op(s_dest), .ex_wb_mux_op(s_wb),
    .ex_rs1_data_op(s_d1), .ex_rs2_data_op(s_d2), .ex_imm_op(s_imm), .ex_pc_op(s_pc),
    .stall_op(s_stall), .stall_cnt_op(s_stall_cnt), .flush_cnt_op(s_flush_cnt)
  );

  // Reference model: contents of the EX slot plus unbounded event counts.
  logic m_valid;
  logic [6:0] m_op;
  logic [4:0] m_rs1, m_rs2, m_dest;
  write_back_mux_selector m_wb;
  logic [DW-1:0] m_d1, m_d2, m_imm, m_pc;
  int m_scnt, m_fcnt;
  logic exp_stall, obs_stall, obs_s_stall;
  int errors = 0;
  int checks = 0;

  function automatic logic model_stall();
    logic rs1_used, rs2_used;
    rs1_used = (id_op == OPCODE_OP) || (id_op == OPCODE_OPIMM) || (id_op == OPCODE_LOAD);
    rs2_used = (id_op == OPCODE_OP);
    return STALL_EN && reset && !flush && m_valid && (m_op == OPCODE_LOAD) &&
           (m_dest != 5'd0) && id_valid &&
           ((rs1_used && id_rs1 == m_dest) || (rs2_used && id_rs2 == m_dest));
  endfunction

  function automatic int sat(input int c, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (c > lim) ? lim : c;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_valid, m_op, m_rs1, m_rs2, m_dest, m_wb, m_d1, m_d2, m_imm, m_pc};
  endfunction

  task automatic model_bubble();
    m_valid = 1'b0; m_op = 7'h00; m_rs1 = 5'd0; m_rs2 = 5'd0; m_dest = 5'd0;
    m_wb = NO_WRITEBACK; m_d1 = '0; m_d2 = '0; m_imm = '0; m_pc = '0;
  endtask

  // Settles inputs, samples stall, clocks once, advances the model, returns #1 after the edge.
  task automatic drive_cycle();
    #1;
    exp_stall   = model_stall();
    obs_stall   = stall;
    obs_s_stall = s_stall;
    @(posedge clk);
    if (!reset) begin
      model_bubble(); m_scnt = 0; m_fcnt = 0;
    end else if (flush) begin
      model_bubble(); m_fcnt++;
    end else if (exp_stall) begin
      model_bubble(); m_scnt++;
    end else if (id_valid) begin
      m_valid = 1'b1; m_op = id_op; m_rs1 = id_rs1; m_rs2 = id_rs2; m_dest = id_dest;
      m_wb = id_wb; m_d1 = id_d1; m_d2 = id_d2; m_imm = id_imm; m_pc = id_pc;
    end else begin
      model_bubble();
    end
    #1;
  endtask

  task automatic present(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] d, input write_back_mux_selector wb);
    id_valid = 1'b1; id_op = op; id_rs1 = r1; id_rs2 = r2; id_dest = d; id_wb = wb;
    id_d1 = $urandom; id_d2 = $urandom; id_imm = $urandom; id_pc = $urandom;
  endtask

  task automatic do_reset();
    reset = 1'b0; flush = 1'b0;
    present(OPCODE_OP, 5'd1, 5'd2, 5'd3, WB_ALU);
    drive_cycle();
    drive_cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0;
    present(OPCODE_LOAD, 5'd4, 5'd0, 5'd5, WB_LOAD);
    drive_cycle();
    drive_cycle();
    checks++;
    if ({ex_valid, ex_op, ex_rs1, ex_rs2, ex_dest, ex_wb, ex_d1, ex_d2, ex_imm, ex_pc} !== '0)
      begin errors++; $display("FAIL reset_bubble: ex_valid=%0b ex_op=%h ex_wb=%0d", ex_valid, ex_op, ex_wb); end
    checks++;
    if (stall_cnt !== '0 || flush_cnt !== '0 || obs_stall !== 1'b0)
      begin errors++; $display("FAIL reset_counters: stall=%0b scnt=%0d fcnt=%0d want 0", obs_stall, stall_cnt, flush_cnt); end
    reset = 1'b1;
    drive_cycle();
    checks++;
    if (ex_valid !== 1'b1 || ex_pc !== id_pc || ex_dest !== 5'd5)
      begin errors++; $display("FAIL first_capture: valid=%0b pc=%h dest=%0d want 1 %h 5", ex_valid, ex_pc, ex_dest, id_pc); end
  endtask

  task automatic test_load_use();
    do_reset();
    present(OPCODE_LOAD, 5'd1, 5'd0, 5'd5, WB_LOAD);
    drive_cycle();
    present(OPCODE_OP, 5'd5, 5'd6, 5'd7, WB_ALU);
    drive_cycle();
    checks++;
    if (obs_stall !== STALL_EN)
      begin errors++; $display("FAIL load_use_stall: got %0b want %0b", obs_stall, STALL_EN); end
    checks++;
    if (ex_valid !== !STALL_EN || ex_wb !== (STALL_EN ? NO_WRITEBACK : WB_ALU) || stall_cnt !== CW'(STALL_EN))
      begin errors++; $display("FAIL load_use_bubble: valid=%0b wb=%0d scnt=%0d", ex_valid, ex_wb, stall_cnt); end
    drive_cycle();
    checks++;
    if (obs_stall !== 1'b0 || ex_valid !== 1'b1 || ex_op !== OPCODE_OP || ex_dest !== 5'd7)
      begin errors++; $display("FAIL load_use_capture: stall=%0b valid=%0b op=%h dest=%0d want 0 1 33 7", obs_stall, ex_valid, ex_op, ex_dest); end
    checks++;
    if ({ex_valid, ex_op, ex_rs1, ex_rs2, ex_dest, ex_wb, ex_d1, ex_d2, ex_imm, ex_pc} !== exp_vec())
      begin errors++; $display("FAIL load_use_fields: got %h want %h", {ex_valid, ex_op, ex_rs1, ex_rs2, ex_dest, ex_wb, ex_d1, ex_d2, ex_imm, ex_pc}, exp_vec()); end
  endtask

  task automatic test_no_hazard();
    do_reset();
    present(OPCODE_LOAD, 5'd1, 5'd0, 5'd5, WB_LOAD);
    drive_cycle();
    present(OPCODE_OPIMM, 5'd6, 5'd5, 5'd7, WB_ALU);
    drive_cycle();
    checks++;
    if (obs_stall !== 1'b0 || ex_valid !== 1'b1 || ex_op !== OPCODE_OPIMM)
      begin errors++; $display("FAIL opimm_rs2: stall=%0b valid=%0b op=%h want 0 1 13", obs_stall, ex_valid, ex_op); end
    present(OPCODE_LOAD, 5'd1, 5'd0, 5'd0, WB_LOAD);
    drive_cycle();
    present(OPCODE_OP, 5'd0, 5'd0, 5'd7, WB_ALU);
    drive_cycle();
    checks++;
    if (obs_stall !== 1'b0 || ex_valid !== 1'b1 || ex_op !== OPCODE_OP || stall_cnt !== '0)
      begin errors++; $display("FAIL load_x0: stall=%0b valid=%0b op=%h scnt=%0d", obs_stall, ex_valid, ex_op, stall_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    present(OPCODE_LOAD, 5'd1, 5'd0, 5'd5, WB_LOAD);
    drive_cycle();
    present(OPCODE_OP, 5'd5, 5'd6, 5'd7, WB_ALU);
    flush = 1'b1;
    drive_cycle();
    flush = 1'b0;
    checks++;
    if (obs_stall !== 1'b0 || ex_valid !== 1'b0 || flush_cnt !== 16'd1 || stall_cnt !== 16'd0)
      begin errors++; $display("FAIL flush_over_stall: stall=%0b valid=%0b fcnt=%0d scnt=%0d want 0 0 1 0", obs_stall, ex_valid, flush_cnt, stall_cnt); end
    present(OPCODE_LOAD, 5'd1, 5'd0, 5'd5, WB_LOAD);
    drive_cycle();
    present(OPCODE_OP, 5'd6, 5'd5, 5'd7, WB_ALU);
    drive_cycle();
    flush = 1'b1;
    drive_cycle();
    flush = 1'b0;
    checks++;
    if (ex_valid !== 1'b0 || flush_cnt !== 16'd2 || stall_cnt !== CW'(STALL_EN))
      begin errors++; $display("FAIL flush_after_stall: valid=%0b fcnt=%0d scnt=%0d", ex_valid, flush_cnt, stall_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    present(OPCODE_LOAD, 5'd1, 5'd0, 5'd5, WB_LOAD);
    drive_cycle();
    present(OPCODE_LOAD, 5'd5, 5'd0, 5'd6, WB_LOAD);
    drive_cycle();
    checks++;
    if (obs_stall !== STALL_EN)
      begin errors++; $display("FAIL b2b_first: stall=%0b want %0b", obs_stall, STALL_EN); end
    drive_cycle();
    checks++;
    if (obs_stall !== 1'b0 || ex_valid !== 1'b1 || ex_op !== OPCODE_LOAD || ex_dest !== 5'd6 || stall_cnt !== CW'(STALL_EN))
      begin errors++; $display("FAIL b2b_second: stall=%0b valid=%0b dest=%0d scnt=%0d", obs_stall, ex_valid, ex_dest, stall_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    present(OPCODE_LOAD, 5'd1, 5'd0, 5'd5, WB_LOAD);
    drive_cycle();
    present(OPCODE_OP, 5'd5, 5'd5, 5'd7, WB_ALU);
    reset = 1'b0;
    drive_cycle();
    reset = 1'b1;
    checks++;
    if (obs_stall !== 1'b0 || ex_valid !== 1'b0 || stall_cnt !== '0 || flush_cnt !== '0)
      begin errors++; $display("FAIL reset_mid_stall: stall=%0b valid=%0b scnt=%0d fcnt=%0d", obs_stall, ex_valid, stall_cnt, flush_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      present(OPCODE_OP, 5'($urandom_range(0, 31)), 5'd1, 5'd2, WB_ALU);
      flush = 1'b1;
      drive_cycle();
    end
    flush = 1'b0;
    checks++;
    if (s_flush_cnt !== 4'hF || flush_cnt !== 16'd20)
      begin errors++; $display("FAIL flush_saturate: small=%0d wide=%0d want 15 20", s_flush_cnt, flush_cnt); end
    for (int i = 0; i < 20; i++) begin
      present(OPCODE_LOAD, 5'd1, 5'd0, 5'd5, WB_LOAD);
      drive_cycle();
      present(OPCODE_OP, 5'd5, 5'd6, 5'd7, WB_ALU);
      drive_cycle();
      drive_cycle();
    end
    checks++;
    if (s_stall_cnt !== (STALL_EN ? 4'hF : 4'h0) || stall_cnt !== (STALL_EN ? 16'd20 : 16'd0))
      begin errors++; $display("FAIL stall_saturate: small=%0d wide=%0d", s_stall_cnt, stall_cnt); end
  endtask

  task automatic test_random();
    logic [6:0] ops[5];
    ops[0] = OPCODE_OP; ops[1] = OPCODE_OPIMM; ops[2] = OPCODE_LOAD; ops[3] = 7'h23; ops[4] = 7'h63;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) != 0);
      flush = ($urandom_range(0, 9) == 0);
      present(ops[$urandom_range(0, 4)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), write_back_mux_selector'($urandom_range(0, 3)));
      id_valid = ($urandom_range(0, 4) != 0);
      drive_cycle();
      checks++;
      if (obs_stall !== exp_stall || obs_s_stall !== exp_stall)
        begin errors++; $display("FAIL rand_stall[%0d]: got %0b/%0b want %0b", i, obs_stall, obs_s_stall, exp_stall); end
      checks++;
      if ({ex_valid, ex_op, ex_rs1, ex_rs2, ex_dest, ex_wb, ex_d1, ex_d2, ex_imm, ex_pc} !== exp_vec())
        begin errors++; $display("FAIL rand_ex[%0d]: got %h want %h", i, {ex_valid, ex_op, ex_rs1, ex_rs2, ex_dest, ex_wb, ex_d1, ex_d2, ex_imm, ex_pc}, exp_vec()); end
      checks++;
      if (int'(stall_cnt) !== sat(m_scnt, CW) || int'(flush_cnt) !== sat(m_fcnt, CW))
        begin errors++; $display("FAIL rand_cnt[%0d]: scnt=%0d fcnt=%0d want %0d %0d", i, stall_cnt, flush_cnt, sat(m_scnt, CW), sat(m_fcnt, CW)); end
      checks++;
      if (int'(s_stall_cnt) !== sat(m_scnt, SW) || int'(s_flush_cnt) !== sat(m_fcnt, SW))
        begin errors++; $display("FAIL rand_small_cnt[%0d]: scnt=%0d fcnt=%0d want %0d %0d", i, s_stall_cnt, s_flush_cnt, sat(m_scnt, SW), sat(m_fcnt, SW)); end
    end
    reset = 1'b1;
    flush = 1'b0;
  endtask

  initial begin
    model_bubble();
    m_scnt = 0; m_fcnt = 0;
    reset = 1'b0; flush = 1'b0; id_valid = 1'b0;
    id_op = 7'h00; id_rs1 = 5'd0; id_rs2 = 5'd0; id_dest = 5'd0; id_wb = NO_WRITEBACK;
    id_d1 = '0; id_d2 = '0; id_imm = '0; id_pc = '0;
    #2;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_flush();
    test_back_to_back();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
